// File: rtl/rr_arbiter_oh_if.sv
// Request/grant bundle between requesters, the round-robin arbiter and the
// consumer that drives ready and decodes the one-hot grant.
interface rr_arbiter_oh_if #(
    parameter int NumReq = 4
);
    logic [NumReq-1:0] req_i;
    logic              ready_i;
    logic [NumReq-1:0] gnt_oh_o;
    logic              valid_o;
    logic              locked_o;

    modport master (
        input  req_i,
        input  ready_i,
        output gnt_oh_o,
        output valid_o,
        output locked_o
    );

    modport slave (
        output req_i,
        output ready_i,
        input  gnt_oh_o,
        input  valid_o,
        input  locked_o
    );
endinterface

// File: rtl/rr_arbiter_oh.sv
// Round-robin arbiter with one-hot grant; the grant is frozen while the
// consumer stalls so the downstream select index stays stable.
module rr_arbiter_oh #(
    parameter int NumReq = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    rr_arbiter_oh_if.master     bus
);
    logic [NumReq-1:0] mask_q;
    logic [NumReq-1:0] gnt_q;
    logic              lock_q;

    logic [NumReq-1:0] masked;
    logic [NumReq-1:0] pick;
    logic [NumReq-1:0] arb_gnt;
    logic [NumReq-1:0] gnt;
    logic              valid;
    logic              fire;

    // Prefer requesters above the last winner; fall back to the full vector.
    assign masked  = bus.req_i & mask_q;
    assign pick    = (|masked) ? masked : bus.req_i;
    assign arb_gnt = pick & (~pick + NumReq'(1));

    assign gnt   = lock_q ? gnt_q : arb_gnt;
    assign valid = lock_q | (|bus.req_i);
    assign fire  = valid & bus.ready_i;

    assign bus.gnt_oh_o = rst_ni ? gnt : '0;
    assign bus.valid_o  = rst_ni & valid;
    assign bus.locked_o = rst_ni & lock_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mask_q <= '0;
            lock_q <= 1'b0;
            gnt_q  <= '0;
        end else if (fire) begin
            // Bits strictly above the winner; granting the top bit yields zero.
            mask_q <= ~(gnt | (gnt - NumReq'(1)));
            lock_q <= 1'b0;
        end else if (valid) begin
            lock_q <= 1'b1;
            gnt_q  <= gnt;
        end
    end
endmodule

// File: tb/tb_rr_arbiter_oh.sv
// Directed scenarios plus a randomized run against an index-based model.
module tb_rr_arbiter_oh;
    localparam int N = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   passed;

    rr_arbiter_oh_if #(.NumReq(N)) bus ();

    rr_arbiter_oh #(.NumReq(N)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic [N-1:0] r, input logic rd, input logic rs);
        @(negedge clk);
        bus.req_i   = r;
        bus.ready_i = rd;
        rst_n       = rs;
        #2;
    endtask

    task automatic test_reset();
        step(4'b1111, 1'b1, 1'b0);
        checks++;
        if ({bus.gnt_oh_o, bus.valid_o, bus.locked_o} !== 6'b0000_0_0)
            $display("FAIL reset_outputs got %b exp %b",
                     {bus.gnt_oh_o, bus.valid_o, bus.locked_o}, 6'b0000_0_0);
        else passed++;
        step(4'b1111, 1'b1, 1'b1);
        checks++;
        if ({bus.gnt_oh_o, bus.valid_o, bus.locked_o} !== 6'b0001_1_0)
            $display("FAIL reset_first_grant got %b exp %b",
                     {bus.gnt_oh_o, bus.valid_o, bus.locked_o}, 6'b0001_1_0);
        else passed++;
    endtask

    task automatic test_all_req();
        logic [N-1:0] seq [5];
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        step(4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, 1'b1, 1'b1);
            checks++;
            if ({bus.gnt_oh_o, bus.valid_o, bus.locked_o} !== {seq[i], 2'b10})
                $display("FAIL all_req[%0d] got %b exp %b", i,
                         {bus.gnt_oh_o, bus.valid_o, bus.locked_o}, {seq[i], 2'b10});
            else passed++;
        end
    endtask

    task automatic test_sparse();
        logic [N-1:0] seq [4];
        seq = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
        step(4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(4'b1010, 1'b1, 1'b1);
            checks++;
            if ({bus.gnt_oh_o, bus.valid_o, bus.locked_o} !== {seq[i], 2'b10})
                $display("FAIL sparse[%0d] got %b exp %b", i,
                         {bus.gnt_oh_o, bus.valid_o, bus.locked_o}, {seq[i], 2'b10});
            else passed++;
        end
    endtask

    task automatic test_stall_lock();
        logic [N-1:0] reqs [6];
        logic         rdys [6];
        logic [5:0]   exps [6];
        reqs = '{4'b0110, 4'b0110, 4'b0110, 4'b0100, 4'b0100, 4'b0100};
        rdys = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        exps = '{6'b0010_1_0, 6'b0010_1_1, 6'b0010_1_1,
                 6'b0010_1_1, 6'b0010_1_1, 6'b0100_1_0};
        step(4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(reqs[i], rdys[i], 1'b1);
            checks++;
            if ({bus.gnt_oh_o, bus.valid_o, bus.locked_o} !== exps[i])
                $display("FAIL stall_lock[%0d] got %b exp %b", i,
                         {bus.gnt_oh_o, bus.valid_o, bus.locked_o}, exps[i]);
            else passed++;
        end
    endtask

    task automatic test_wrap();
        logic [N-1:0] reqs [5];
        logic [5:0]   exps [5];
        reqs = '{4'b0100, 4'b0011, 4'b1000, 4'b1001, 4'b1001};
        exps = '{6'b0100_1_0, 6'b0001_1_0, 6'b1000_1_0, 6'b0001_1_0, 6'b1000_1_0};
        step(4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(reqs[i], 1'b1, 1'b1);
            checks++;
            if ({bus.gnt_oh_o, bus.valid_o, bus.locked_o} !== exps[i])
                $display("FAIL wrap[%0d] got %b exp %b", i,
                         {bus.gnt_oh_o, bus.valid_o, bus.locked_o}, exps[i]);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_lock();
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0100, 1'b0, 1'b1);
        step(4'b0100, 1'b0, 1'b1);
        checks++;
        if ({bus.gnt_oh_o, bus.valid_o, bus.locked_o} !== 6'b0100_1_1)
            $display("FAIL mid_lock_held got %b exp %b",
                     {bus.gnt_oh_o, bus.valid_o, bus.locked_o}, 6'b0100_1_1);
        else passed++;
        step(4'b0100, 1'b0, 1'b0);
        checks++;
        if ({bus.gnt_oh_o, bus.valid_o, bus.locked_o} !== 6'b0000_0_0)
            $display("FAIL mid_lock_rst got %b exp %b",
                     {bus.gnt_oh_o, bus.valid_o, bus.locked_o}, 6'b0000_0_0);
        else passed++;
        step(4'b1111, 1'b1, 1'b1);
        checks++;
        if ({bus.gnt_oh_o, bus.valid_o, bus.locked_o} !== 6'b0001_1_0)
            $display("FAIL mid_lock_after got %b exp %b",
                     {bus.gnt_oh_o, bus.valid_o, bus.locked_o}, 6'b0001_1_0);
        else passed++;
    endtask

    task automatic test_idle();
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0010, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(4'b0000, i[0], 1'b1);
            checks++;
            if ({bus.gnt_oh_o, bus.valid_o, bus.locked_o} !== 6'b0000_0_0)
                $display("FAIL idle[%0d] got %b exp %b", i,
                         {bus.gnt_oh_o, bus.valid_o, bus.locked_o}, 6'b0000_0_0);
            else passed++;
        end
        step(4'b1111, 1'b1, 1'b1);
        checks++;
        if ({bus.gnt_oh_o, bus.valid_o, bus.locked_o} !== 6'b0100_1_0)
            $display("FAIL idle_resume got %b exp %b",
                     {bus.gnt_oh_o, bus.valid_o, bus.locked_o}, 6'b0100_1_0);
        else passed++;
    endtask

    // Model tracks the last winning index and a held index; the next winner
    // is the first requester after the last one, wrapping to the lowest.
    task automatic test_random();
        int           last;
        int           held;
        bit           lk;
        int           idx;
        logic [N-1:0] r;
        logic         rd;
        logic         rs;
        logic [5:0]   exp;
        bit           v;
        last = -1;
        held = 0;
        lk   = 1'b0;
        step(4'b0000, 1'b0, 1'b0);
        for (int c = 0; c < 400; c++) begin
            r  = N'($urandom_range((1 << N) - 1));
            rd = ($urandom_range(2) != 0);
            rs = ($urandom_range(39) != 0);
            step(r, rd, rs);
            idx = -1;
            if (lk) idx = held;
            else begin
                for (int k = last + 1; k < N && idx < 0; k++) if (r[k]) idx = k;
                for (int k = 0; k < N && idx < 0; k++) if (r[k]) idx = k;
            end
            v   = rs && (idx >= 0);
            exp = {(v ? N'(1 << idx) : N'(0)), v, rs & lk};
            checks++;
            if ({bus.gnt_oh_o, bus.valid_o, bus.locked_o} !== exp)
                $display("FAIL random[%0d] req=%b rdy=%b rst_n=%b got %b exp %b",
                         c, r, rd, rs, {bus.gnt_oh_o, bus.valid_o, bus.locked_o}, exp);
            else passed++;
            if (!rs) begin
                last = -1;
                lk   = 1'b0;
            end else if (v && rd) begin
                last = idx;
                lk   = 1'b0;
            end else if (v) begin
                lk   = 1'b1;
                held = idx;
            end
        end
    endtask

    initial begin
        checks      = 0;
        passed      = 0;
        rst_n       = 1'b0;
        bus.req_i   = '0;
        bus.ready_i = 1'b0;
        test_reset();
        test_all_req();
        test_sparse();
        test_stall_lock();
        test_wrap();
        test_reset_mid_lock();
        test_idle();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
